// File: rtl/fa_pkg.sv
// Shared types and helpers for the iterative carry-feedback adder
// sequencer and its result checker.
package fa_pkg;

    localparam int M_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } fa_ctrl_state_e;

    // {cout, ovf} for a default-width add; s is the sum modulo 2^M.
    function automatic logic [1:0] flags_f(
        input logic [M_DEF-1:0] a,
        input logic             b_msb,
        input logic [M_DEF-1:0] s
    );
        logic cout;
        logic ovf;
        cout = (s < a);
        ovf  = (a[M_DEF-1] == b_msb) & (s[M_DEF-1] != a[M_DEF-1]);
        return {cout, ovf};
    endfunction

endpackage

// File: rtl/fa_flag_calc.sv
// Combinational carry-out / signed-overflow generator for an M-bit add,
// derived from the operands and the modulo-2^M sum.
import fa_pkg::*;

module fa_flag_calc #(
    parameter int M = M_DEF
) (
    input  logic [M-1:0] a_i,
    input  logic         b_msb_i,
    input  logic [M-1:0] s_i,
    output logic         cout_o,
    output logic         ovf_o
);

    // A wrapped unsigned sum is always smaller than either operand.
    assign cout_o = (s_i < a_i);
    assign ovf_o  = (a_i[M-1] == b_msb_i) & (s_i[M-1] != a_i[M-1]);

endmodule

// File: rtl/fa_iter_ctrl.sv
// Sequencer in front of the iterative carry-feedback adder: load, wait
// for the zero-carry flag with a timeout, capture and hand off the sum.
import fa_pkg::*;

module fa_iter_ctrl #(
    parameter int M        = M_DEF,
    parameter int LOAD_CYC = 2,
    parameter int MAX_ITER = M + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [M-1:0] op_a_i,
    input  logic [M-1:0] op_b_i,
    output logic [M-1:0] add_a_o,
    output logic [M-1:0] add_b_o,
    output logic         add_load_o,
    input  logic         add_done_i,
    input  logic [M-1:0] add_sum_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [M-1:0] sum_o,
    output logic         cout_o,
    output logic         ovf_o,
    output logic         err_o,
    output logic         busy_o
);

    localparam int CW = $clog2(MAX_ITER + 1);

    fa_ctrl_state_e state_q, state_d;
    logic [M-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [M-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic           err_q, err_d;

    logic           cap_cout;
    logic           cap_ovf;
    logic           done_ok;
    logic           timeout;

    fa_flag_calc #(.M(M)) u_flags (
        .a_i     (a_q),
        .b_msb_i (b_q[M-1]),
        .s_i     (add_sum_i),
        .cout_o  (cap_cout),
        .ovf_o   (cap_ovf)
    );

    // The flag seen on the first RUN cycle may be left over from the
    // previous operation, so it only counts from cnt==1 onwards.
    assign done_ok = add_done_i & (cnt_q != '0);
    assign timeout = (cnt_q == CW'(MAX_ITER));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == CW'(LOAD_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (done_ok || timeout) begin
                    sum_d   = add_sum_i;
                    cout_d  = cap_cout;
                    ovf_d   = cap_ovf;
                    err_d   = ~done_ok;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign add_load_o  = (state_q == LOAD);
    assign out_valid_o = (state_q == HOLD);
    assign busy_o      = (state_q != IDLE);
    assign add_a_o     = a_q;
    assign add_b_o     = b_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fa_iter_ctrl.sv
// Directed bench for fa_iter_ctrl with a behavioural adder model
// whose done flag and sum are set per vector.
module tb_fa_iter_ctrl;

    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [M-1:0] op_a_i;
    logic [M-1:0] op_b_i;
    logic [M-1:0] add_a_o;
    logic [M-1:0] add_b_o;
    logic         add_load_o;
    logic         add_done_i;
    logic [M-1:0] add_sum_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [M-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;
    logic         err_o;
    logic         busy_o;

    always #5 clk = ~clk;

    fa_iter_ctrl #(.M(M), .LOAD_CYC(2), .MAX_ITER(M + 1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .add_a_o     (add_a_o),
        .add_b_o     (add_b_o),
        .add_load_o  (add_load_o),
        .add_done_i  (add_done_i),
        .add_sum_i   (add_sum_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    // Adder model: cycles since load dropped, flag rises at done_at.
    int           run_cnt = 0;
    int           done_at;
    logic         done_en;
    logic         done_force;
    logic         sum_ramp;
    logic [M-1:0] sum_base;

    always @(posedge clk) begin
        if (add_load_o) run_cnt <= 0;
        else if (run_cnt < 1000) run_cnt <= run_cnt + 1;
    end

    assign add_done_i = done_force |
        (done_en & ~add_load_o & (run_cnt >= done_at));
    assign add_sum_i = sum_base + (sum_ramp ? run_cnt[M-1:0] : '0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] sum;
        int           done_at;
        int           mode;
        logic [M-1:0] es;
        logic         ec;
        logic         eo;
        logic         ee;
        int           elat;
    } vec_t;

    vec_t vecs[6];

    task automatic set_model(input vec_t v);
        sum_base   = v.sum;
        done_at    = v.done_at;
        done_en    = (v.mode == 0);
        done_force = (v.mode == 1);
        sum_ramp   = (v.mode == 2);
    endtask

    task automatic accept(input logic [M-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        op_a_i     = a;
        op_b_i     = b;
        in_valid_i = 1'b1;
        chk("in_ready_before_accept", in_ready_o, 1'b1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        chk("load_after_accept", add_load_o, 1'b1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid_o) break;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid_o) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        chk("valid_drop", out_valid_o, 1'b0);
        chk("ready_back", in_ready_o, 1'b1);
    endtask

    task automatic run_vec(input int i);
        int lat;
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        set_model(v);
        accept(v.a, v.b);
        wait_valid(lat);
        @(negedge clk);
        chk($sformatf("v%0d_lat", i), lat, v.elat);
        chk($sformatf("v%0d_sum", i), sum_o, v.es);
        chk($sformatf("v%0d_cout", i), cout_o, v.ec);
        chk($sformatf("v%0d_ovf", i), ovf_o, v.eo);
        chk($sformatf("v%0d_err", i), err_o, v.ee);
        chk($sformatf("v%0d_add_a", i), add_a_o, v.a);
        chk($sformatf("v%0d_add_b", i), add_b_o, v.b);
        release_out();
        done_force = 1'b0;
    endtask

    initial begin
        int lat;
        logic spurious;
        logic [M-1:0] held;

        vecs[0] = '{16'h0003, 16'h0005, 16'h0008, 2, 0,
                    16'h0008, 1'b0, 1'b0, 1'b0, 5};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 1, 0,
                    16'h0000, 1'b1, 1'b0, 1'b0, 4};
        vecs[2] = '{16'h7FFF, 16'h0001, 16'h8000, 3, 0,
                    16'h8000, 1'b0, 1'b1, 1'b0, 6};
        vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 2, 0,
                    16'h0000, 1'b1, 1'b1, 1'b0, 5};
        vecs[4] = '{16'h1234, 16'h1111, 16'h2345, 0, 1,
                    16'h2345, 1'b0, 1'b0, 1'b0, 4};
        vecs[5] = '{16'h00F0, 16'h000F, 16'h00FF, 0, 2,
                    16'h0110, 1'b0, 1'b0, 1'b1, 20};

        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        op_a_i      = '0;
        op_b_i      = '0;
        sum_base    = '0;
        done_at     = 1;
        done_en     = 1'b0;
        done_force  = 1'b0;
        sum_ramp    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_load", add_load_o, 1'b0);
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sum", sum_o, 16'h0);
        chk("rst_flags", {cout_o, ovf_o, err_o}, 3'b000);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        set_model(vecs[5]);
        accept(16'h0101, 16'h0202);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready_o, 1'b1);
        chk("midrst_load", add_load_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        spurious = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid_o || busy_o) spurious = 1'b1;
        end
        chk("midrst_no_result", spurious, 1'b0);

        // Backpressure, then back-to-back acceptance.
        @(negedge clk);
        set_model(vecs[0]);
        accept(16'h0003, 16'h0005);
        wait_valid(lat);
        @(negedge clk);
        held       = sum_o;
        op_a_i     = 16'h0100;
        op_b_i     = 16'h0200;
        in_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), out_valid_o, 1'b1);
            chk($sformatf("bp_sum_%0d", k), sum_o, held);
            chk($sformatf("bp_in_ready_%0d", k), in_ready_o, 1'b0);
            @(negedge clk);
        end
        chk("bp_sum_value", held, 16'h0008);
        sum_base    = 16'h0300;
        done_at     = 1;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        chk("bp_valid_drop", out_valid_o, 1'b0);
        chk("bp_ready_next", in_ready_o, 1'b1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        chk("b2b_accepted", add_load_o, 1'b1);
        wait_valid(lat);
        @(negedge clk);
        chk("b2b_lat", lat, 4);
        chk("b2b_sum", sum_o, 16'h0300);
        chk("b2b_add_a", add_a_o, 16'h0100);
        chk("b2b_flags", {cout_o, ovf_o, err_o}, 3'b000);

        // out_ready held high: HOLD lasts one cycle.
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_one_cycle", out_valid_o, 1'b0);
        out_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
